mem_arbiter: RTL

//   Shares the single-port 4096x16 main memory between NREQ requesters
//   (req 0 = CPU fetch/execute, req 1 = I/O loader).

---
 rtl/bascomp_mem_pkg.sv | 16 +
 rtl/mem_arbiter_rr_picker.sv | 34 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bascomp_mem_pkg.sv
// Shared definitions for the main-memory arbiter: memory geometry and the
// transaction state encoding used by mem_arbiter.
package bascomp_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  // One memory transaction walks IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection for the memory arbiter. In round-robin mode
// the search starts at the pointer and wraps; in fixed mode index 0 always
// has the highest priority and the pointer is ignored.
module rr_picker #(
  parameter int NREQ    = 2,
  parameter int RR_MODE = 1,
  parameter int PTR_W   = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_onehot,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  // Walk priority distances from nearest to farthest and take the first
  // requester found; distance is measured from the pointer in RR mode.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int b = 0; b < NREQ; b++) begin
        if (!o_valid && i_req[b] &&
            (((RR_MODE != 0) ? ((b - int'(i_ptr) + NREQ) % NREQ) : b) == k)) begin
          o_valid     = 1'b1;
          o_onehot[b] = 1'b1;
          o_idx       = PTR_W'(b);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port main memory between NREQ requesters.
// Each access is a four-cycle request/ack transaction that drives the
// memory pins and captures the registered 1-cycle read result.
module mem_arbiter
  import bascomp_mem_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RR_MODE = 1,
  parameter int ADDR_W  = bascomp_mem_pkg::ADDR_W,
  parameter int DATA_W  = bascomp_mem_pkg::DATA_W
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_we,
  input  logic [NREQ*ADDR_W-1:0] i_addr,
  input  logic [NREQ*DATA_W-1:0] i_wdata,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ-1:0]        o_ack,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_busy,
  output logic [ADDR_W-1:0]      o_mem_adress,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic [DATA_W-1:0]      o_mem_indata,
  input  logic [DATA_W-1:0]      i_mem_outdata
);

  localparam int PTR_W = (NREQ > 2) ? 2 : 1;

  arb_state_t         r_state, w_nextState;
  logic [NREQ-1:0]    r_gnt, w_nextGnt;
  logic [NREQ-1:0]    r_ack, w_nextAck;
  logic [DATA_W-1:0]  r_rdata, w_nextRdata;
  logic [ADDR_W-1:0]  r_adr, w_nextAdr;
  logic [DATA_W-1:0]  r_indata, w_nextIndata;
  logic               r_read, w_nextRead;
  logic               r_write, w_nextWrite;
  logic               r_isWrite, w_nextIsWrite;
  logic [PTR_W-1:0]   r_ptr, w_nextPtr;

  logic [NREQ-1:0]    w_pickOnehot;
  logic [PTR_W-1:0]   w_pickIdx;
  logic               w_pickValid;
  logic [ADDR_W-1:0]  w_selAddr;
  logic [DATA_W-1:0]  w_selWdata;
  logic               w_selWe;
  logic [PTR_W-1:0]   w_ptrInc;

  rr_picker #(
    .NREQ    (NREQ),
    .RR_MODE (RR_MODE),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pickOnehot),
    .o_idx    (w_pickIdx),
    .o_valid  (w_pickValid)
  );

  assign w_selAddr  = i_addr[int'(w_pickIdx)*ADDR_W +: ADDR_W];
  assign w_selWdata = i_wdata[int'(w_pickIdx)*DATA_W +: DATA_W];
  assign w_selWe    = i_we[w_pickIdx];

  // Round-robin pointer moves to the requester just after the winner, wrapping.
  always_comb begin
    if (int'(w_pickIdx) == NREQ - 1) w_ptrInc = '0;
    else                             w_ptrInc = w_pickIdx + PTR_W'(1);
  end

  // Next-state and next-register logic; every register holds unless its
  // state says otherwise, so the request inputs only matter in IDLE.
  always_comb begin
    w_nextState   = r_state;
    w_nextGnt     = r_gnt;
    w_nextAck     = r_ack;
    w_nextRdata   = r_rdata;
    w_nextAdr     = r_adr;
    w_nextIndata  = r_indata;
    w_nextRead    = r_read;
    w_nextWrite   = r_write;
    w_nextIsWrite = r_isWrite;
    w_nextPtr     = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_pickValid) begin
          w_nextGnt     = w_pickOnehot;
          w_nextAdr     = w_selAddr;
          w_nextIndata  = w_selWdata;
          w_nextRead    = ~w_selWe;
          w_nextWrite   = w_selWe;
          w_nextIsWrite = w_selWe;
          w_nextPtr     = w_ptrInc;
          w_nextState   = ISSUE;
        end else begin
          w_nextRead  = 1'b0;
          w_nextWrite = 1'b0;
        end
      end
      ISSUE: begin
        w_nextRead  = 1'b0;
        w_nextWrite = 1'b0;
        w_nextState = WAIT;
      end
      WAIT: begin
        if (!r_isWrite) w_nextRdata = i_mem_outdata;
        w_nextAck   = r_gnt;
        w_nextState = ACK;
      end
      ACK: begin
        w_nextAck   = '0;
        w_nextGnt   = '0;
        w_nextState = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction at once,
  // pulling the memory strobes low before the memory can act on them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
      r_adr     <= '0;
      r_indata  <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_isWrite <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_nextState;
      r_gnt     <= w_nextGnt;
      r_ack     <= w_nextAck;
      r_rdata   <= w_nextRdata;
      r_adr     <= w_nextAdr;
      r_indata  <= w_nextIndata;
      r_read    <= w_nextRead;
      r_write   <= w_nextWrite;
      r_isWrite <= w_nextIsWrite;
      r_ptr     <= w_nextPtr;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_ack        = r_ack;
  assign o_rdata      = r_rdata;
  assign o_busy       = (r_state != IDLE);
  assign o_mem_adress = r_adr;
  assign o_mem_read   = r_read;
  assign o_mem_write  = r_write;
  assign o_mem_indata = r_indata;

endmodule
